// File: rtl/hpi_responder.sv
// hpi_responder: device-side CY7C67200 HPI model with address pointer, word RAM, two mailboxes and status.
// Ports: Clk/Reset_n (async active-low), OTG_* host bus (OTG_DATA driven only in reads, OTG_RST_N soft reset),
//        dev_mbx_in/_full/_ack inbound mailbox, dev_mbx_out/_wr outbound mailbox, err sticky error.
module hpi_responder #(
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic        Clk,
  input  logic        Reset_n,
  inout  wire  [15:0] OTG_DATA,
  input  logic [1:0]  OTG_ADDR,
  input  logic        OTG_CS_N,
  input  logic        OTG_RD_N,
  input  logic        OTG_WR_N,
  input  logic        OTG_RST_N,
  output logic [15:0] dev_mbx_in,
  output logic        dev_mbx_in_full,
  input  logic        dev_mbx_ack,
  input  logic [15:0] dev_mbx_out,
  input  logic        dev_mbx_wr,
  output logic        err
);
  typedef enum logic [1:0] {IDLE, WR, RD, ILL} state_t;
  state_t state_q, state_d;
  logic cs_q, rd_q, wr_q;
  logic [1:0] addr_q, acc_q, acc_d;
  logic [15:0] din_q, wdata_q, wdata_d, rdata_q, rdata_d, ptr_q, ptr_d;
  logic [15:0] in_q, in_d, out_q, out_d, rsel;
  logic in_full_q, in_full_d, out_full_q, out_full_d, err_q, err_d, mem_we;
  logic [15:0] mem_q [DEPTH];
  logic [AW-1:0] idx;
  assign idx = ptr_q[AW:1];
  assign rsel = addr_q == 2'd0 ? mem_q[idx] :
                addr_q == 2'd1 ? out_q :
                addr_q == 2'd2 ? ptr_q : {7'b0, in_full_q, 7'b0, out_full_q};
  assign OTG_DATA = (state_q == RD) ? rdata_q : 16'hzzzz;
  assign dev_mbx_in = in_q;
  assign dev_mbx_in_full = in_full_q;
  assign err = err_q;
  // Strobes are stored active-high so the FSM reads naturally.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      cs_q   <= 1'b0;
      rd_q   <= 1'b0;
      wr_q   <= 1'b0;
      addr_q <= 2'd0;
      din_q  <= 16'h0;
    end else begin
      cs_q   <= ~OTG_CS_N;
      rd_q   <= ~OTG_RD_N;
      wr_q   <= ~OTG_WR_N;
      addr_q <= OTG_ADDR;
      din_q  <= OTG_DATA;
    end
  end
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    wdata_d    = wdata_q;
    rdata_d    = rdata_q;
    ptr_d      = ptr_q;
    in_d       = in_q;
    in_full_d  = in_full_q;
    out_d      = out_q;
    out_full_d = out_full_q;
    err_d      = err_q;
    mem_we     = 1'b0;
    if (dev_mbx_ack) in_full_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (cs_q && rd_q && wr_q) begin
          state_d = ILL;
          err_d   = 1'b1;
        end else if (cs_q && wr_q) begin
          state_d = WR;
          acc_d   = addr_q;
          wdata_d = din_q;
        end else if (cs_q && rd_q) begin
          state_d = RD;
          acc_d   = addr_q;
          rdata_d = rsel;
        end
      end
      WR: begin
        if (cs_q && wr_q) wdata_d = din_q;
        else begin
          state_d = IDLE;
          case (acc_q)
            2'd0: begin
              mem_we = 1'b1;
              ptr_d  = ptr_q + 16'd2;
            end
            2'd1: begin
              in_d      = wdata_q;
              in_full_d = 1'b1;
              // An ack in the commit cycle frees the slot, so that is not an overrun.
              if (in_full_q && !dev_mbx_ack) err_d = 1'b1;
            end
            2'd2: ptr_d = wdata_q;
            default: ;
          endcase
        end
      end
      RD: begin
        if (!(cs_q && rd_q)) begin
          state_d = IDLE;
          if (acc_q == 2'd0) ptr_d = ptr_q + 16'd2;
          if (acc_q == 2'd1) out_full_d = 1'b0;
        end
      end
      default: begin
        err_d = 1'b1;
        if (!(cs_q && (rd_q || wr_q))) state_d = IDLE;
      end
    endcase
    if (dev_mbx_wr) begin
      out_d      = dev_mbx_out;
      out_full_d = 1'b1;
    end
    // Soft reset keeps RAM contents and drops any in-flight commit.
    if (!OTG_RST_N) begin
      state_d    = IDLE;
      ptr_d      = 16'h0;
      in_d       = 16'h0;
      in_full_d  = 1'b0;
      out_d      = 16'h0;
      out_full_d = 1'b0;
      err_d      = 1'b0;
      mem_we     = 1'b0;
    end
  end
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      acc_q      <= 2'd0;
      wdata_q    <= 16'h0;
      rdata_q    <= 16'h0;
      ptr_q      <= 16'h0;
      in_q       <= 16'h0;
      in_full_q  <= 1'b0;
      out_q      <= 16'h0;
      out_full_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      acc_q      <= acc_d;
      wdata_q    <= wdata_d;
      rdata_q    <= rdata_d;
      ptr_q      <= ptr_d;
      in_q       <= in_d;
      in_full_q  <= in_full_d;
      out_q      <= out_d;
      out_full_q <= out_full_d;
      err_q      <= err_d;
    end
  end
  always_ff @(posedge Clk) begin
    if (mem_we) mem_q[idx] <= wdata_q;
  end
endmodule

// File: tb/tb_hpi_responder.sv
// tb_hpi_responder: table-driven and scoreboard check of the HPI responder.
module tb_hpi_responder;
  localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2, A_STAT = 2'd3;
  localparam bit W = 1'b0, R = 1'b1;
  typedef struct {
    bit          rd;
    logic [1:0]  a;
    logic [15:0] d;
  } vec_t;
  logic clk = 1'b0, rst_n = 1'b0;
  tri1 [15:0] otg_data;
  logic [15:0] drv_data = 16'h0, mout = 16'h0;
  logic drv_en = 1'b0, cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, otg_rst_n = 1'b1, ack = 1'b0, mwr = 1'b0;
  logic [1:0] addr = 2'd0;
  wire [15:0] mbx_in;
  wire full, err;
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_q[$];
  vec_t tbl[11];
  assign otg_data = drv_en ? drv_data : 16'hzzzz;
  always #5 clk = ~clk;
  hpi_responder dut (
    .Clk(clk), .Reset_n(rst_n), .OTG_DATA(otg_data), .OTG_ADDR(addr),
    .OTG_CS_N(cs_n), .OTG_RD_N(rd_n), .OTG_WR_N(wr_n), .OTG_RST_N(otg_rst_n),
    .dev_mbx_in(mbx_in), .dev_mbx_in_full(full), .dev_mbx_ack(ack),
    .dev_mbx_out(mout), .dev_mbx_wr(mwr), .err(err)
  );
  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask
  task automatic hw(input logic [1:0] a, input logic [15:0] d);
    @(negedge clk);
    addr = a; drv_data = d; drv_en = 1'b1; cs_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(negedge clk);
    cs_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
    repeat (3) @(negedge clk);
  endtask
  task automatic hr(input logic [1:0] a, input logic [15:0] exp, input bit post);
    exp_q.push_back(exp);
    @(negedge clk);
    addr = a; cs_n = 1'b0; rd_n = 1'b0;
    @(negedge clk);
    check("bus_z_pre_rd", otg_data, 16'hFFFF);
    repeat (2) @(negedge clk);
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL sb_empty: got no expected entry for read of addr %0d", a);
    end else check($sformatf("rd_addr%0d", a), otg_data, exp_q.pop_front());
    cs_n = 1'b1; rd_n = 1'b1;
    @(negedge clk);
    if (post) mwr = 1'b1;
    @(negedge clk);
    mwr = 1'b0;
    @(negedge clk);
    check("bus_z_post_rd", otg_data, 16'hFFFF);
  endtask
  task automatic soft_rst();
    @(negedge clk);
    otg_rst_n = 1'b0;
    @(negedge clk);
    otg_rst_n = 1'b1;
  endtask
  initial begin
    tbl = '{
      '{W, A_ADDR, 16'h0010}, '{W, A_DATA, 16'hBEEF}, '{W, A_DATA, 16'h1234},
      '{R, A_ADDR, 16'h0014}, '{W, A_ADDR, 16'h0010}, '{R, A_DATA, 16'hBEEF},
      '{R, A_DATA, 16'h1234}, '{R, A_ADDR, 16'h0014}, '{R, A_STAT, 16'h0000},
      '{W, A_MBX,  16'h00C5}, '{R, A_STAT, 16'h0100}
    };
    repeat (2) @(negedge clk);
    check("rst_err", {15'b0, err}, 16'h0);
    check("rst_full", {15'b0, full}, 16'h0);
    check("rst_mbx_in", mbx_in, 16'h0);
    check("rst_bus_z", otg_data, 16'hFFFF);
    rst_n = 1'b1;
    for (int i = 0; i < 11; i++) begin
      if (tbl[i].rd) hr(tbl[i].a, tbl[i].d, 1'b0);
      else hw(tbl[i].a, tbl[i].d);
    end
    check("mbx_in_c5", mbx_in, 16'h00C5);
    check("mbx_full_set", {15'b0, full}, 16'h1);
    @(negedge clk) ack = 1'b1;
    @(negedge clk) ack = 1'b0;
    hr(A_STAT, 16'h0000, 1'b0);
    @(negedge clk) begin mout = 16'h5A5A; mwr = 1'b1; end
    @(negedge clk) mwr = 1'b0;
    hr(A_STAT, 16'h0001, 1'b0);
    hr(A_MBX, 16'h5A5A, 1'b0);
    hr(A_STAT, 16'h0000, 1'b0);
    @(negedge clk) begin mout = 16'h6B6B; mwr = 1'b1; end
    @(negedge clk) mwr = 1'b0;
    hr(A_MBX, 16'h6B6B, 1'b1);
    hr(A_STAT, 16'h0001, 1'b0);
    hw(A_MBX, 16'h00C5);
    check("no_err_first_mbx", {15'b0, err}, 16'h0);
    hw(A_MBX, 16'h0077);
    check("overrun_mbx_in", mbx_in, 16'h0077);
    check("overrun_err", {15'b0, err}, 16'h1);
    soft_rst();
    check("srst_err", {15'b0, err}, 16'h0);
    check("srst_mbx_in", mbx_in, 16'h0);
    check("srst_full", {15'b0, full}, 16'h0);
    hr(A_STAT, 16'h0000, 1'b0);
    hr(A_MBX, 16'h0000, 1'b0);
    hw(A_ADDR, 16'h0020);
    hw(A_DATA, 16'hA5A5);
    hw(A_ADDR, 16'h0020);
    @(negedge clk) begin cs_n = 1'b0; rd_n = 1'b0; wr_n = 1'b0; end
    repeat (3) @(negedge clk);
    check("ill_bus_z", otg_data, 16'hFFFF);
    check("ill_err", {15'b0, err}, 16'h1);
    cs_n = 1'b1; rd_n = 1'b1; wr_n = 1'b1;
    repeat (3) @(negedge clk);
    hr(A_DATA, 16'hA5A5, 1'b0);
    hr(A_ADDR, 16'h0022, 1'b0);
    soft_rst();
    hw(A_ADDR, 16'hFFFE);
    hw(A_DATA, 16'h0F0F);
    hr(A_ADDR, 16'h0000, 1'b0);
    hw(A_ADDR, 16'hFFFE);
    hr(A_DATA, 16'h0F0F, 1'b0);
    hw(A_ADDR, 16'h0040);
    hw(A_DATA, 16'h1357);
    hw(A_ADDR, 16'h0040);
    @(negedge clk) begin addr = A_DATA; drv_data = 16'h7777; drv_en = 1'b1; cs_n = 1'b0; wr_n = 1'b0; end
    repeat (3) @(negedge clk);
    otg_rst_n = 1'b0; cs_n = 1'b1; wr_n = 1'b1; drv_en = 1'b0;
    @(negedge clk) otg_rst_n = 1'b1;
    repeat (2) @(negedge clk);
    check("abort_err", {15'b0, err}, 16'h0);
    hr(A_ADDR, 16'h0000, 1'b0);
    hw(A_ADDR, 16'h0040);
    hr(A_DATA, 16'h1357, 1'b0);
    hw(A_MBX, 16'h1234);
    hw(A_MBX, 16'h4321);
    @(negedge clk) begin addr = A_STAT; cs_n = 1'b0; rd_n = 1'b0; end
    repeat (3) @(negedge clk);
    check("pre_arst_bus", otg_data, 16'h0100);
    #2 rst_n = 1'b0;
    #1;
    check("arst_bus_z", otg_data, 16'hFFFF);
    check("arst_mbx_in", mbx_in, 16'h0);
    check("arst_full", {15'b0, full}, 16'h0);
    check("arst_err", {15'b0, err}, 16'h0);
    @(negedge clk) begin cs_n = 1'b1; rd_n = 1'b1; rst_n = 1'b1; end
    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
